// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight-load path: loader FSM state encoding and
// the default weight width / lane count used by the weight registers and the
// multiplier array.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } wl_state_e;

  localparam int WL_WEIGHT_BW = 8;
  localparam int WL_NUM_PE    = 4;

  // Width of a lane index; never narrower than one bit.
  function automatic int wl_idx_bw(input int num_lanes);
    return (num_lanes <= 2) ? 1 : $clog2(num_lanes);
  endfunction

endpackage

// File: rtl/weight_shadow_buf.sv
// Shadow register file holding one weight set while it is being assembled.
// Each lane has its own write enable; clr wipes every lane to zero so a short
// set leaves its unwritten lanes at zero. Lanes are exposed on a flat bus with
// lane i at bits [i*WEIGHT_BW +: WEIGHT_BW].
module weight_shadow_buf
  import weight_loader_pkg::*;
#(
  parameter int WEIGHT_BW = WL_WEIGHT_BW,
  parameter int NUM_PE    = WL_NUM_PE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic [NUM_PE-1:0]           lane_we,
  input  logic [WEIGHT_BW-1:0]        wr_data,
  output logic [NUM_PE*WEIGHT_BW-1:0] bus
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
      logic [WEIGHT_BW-1:0] lane_q;

      // Per-lane register: clear wins over a same-cycle write.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          lane_q <= '0;
        end else if (lane_we[gi]) begin
          lane_q <= wr_data;
        end
      end

      assign bus[gi*WEIGHT_BW +: WEIGHT_BW] = lane_q;
    end
  endgenerate

endmodule

// File: rtl/weight_loader.sv
// Weight loader: collects NUM_PE weights from a valid/ready stream into a
// shadow set, waits for load_allow, then broadcasts the set with a one-cycle
// weight_reload strobe. Optional macro WEIGHT_LOADER_ERR_EN adds a sticky
// set_err output flagging short or long sets.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int WEIGHT_BW = WL_WEIGHT_BW,
  parameter int NUM_PE    = WL_NUM_PE,
  parameter int CNT_BW    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WEIGHT_BW-1:0]        in_data,
  input  logic                        in_last,
  input  logic                        load_allow,
  output logic                        weight_reload,
  output logic [NUM_PE*WEIGHT_BW-1:0] weight_bus,
  output logic [CNT_BW-1:0]           sets_loaded,
  output logic                        busy
`ifdef WEIGHT_LOADER_ERR_EN
  ,
  output logic                        set_err
`endif
);

  localparam int IDX_BW = wl_idx_bw(NUM_PE);
  localparam logic [IDX_BW-1:0] IDX_MAX = IDX_BW'(NUM_PE - 1);

  wl_state_e          state_q, state_d;
  logic [IDX_BW-1:0]  idx_q, idx_d;
  logic [CNT_BW-1:0]  cnt_q, cnt_d;
  logic               accept;
  logic               at_last_lane;
  logic               set_done;
  logic [NUM_PE-1:0]  lane_we;

  assign accept       = in_valid && (state_q == ST_FILL);
  assign at_last_lane = (idx_q == IDX_MAX);
  assign set_done     = accept && (at_last_lane || in_last);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_we
      assign lane_we[gi] = accept && (idx_q == IDX_BW'(gi));
    end
  endgenerate

  // State, lane index and set counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: fill lanes, hold until the array is idle, strobe once.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (set_done) begin
            idx_d   = '0;
            state_d = ST_WAIT;
          end else begin
            idx_d = idx_q + IDX_BW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (load_allow) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = cnt_q + CNT_BW'(1);
        state_d = ST_FILL;
      end
      default: begin
        state_d = ST_FILL;
        idx_d   = '0;
      end
    endcase
  end

  // Leaving LOAD clears the shadow so the next set starts from all-zero lanes.
  weight_shadow_buf #(
    .WEIGHT_BW(WEIGHT_BW),
    .NUM_PE   (NUM_PE)
  ) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_LOAD),
    .lane_we(lane_we),
    .wr_data(in_data),
    .bus    (weight_bus)
  );

  assign in_ready      = (state_q == ST_FILL);
  assign weight_reload = (state_q == ST_LOAD);
  assign busy          = (state_q != ST_FILL);
  assign sets_loaded   = cnt_q;

`ifdef WEIGHT_LOADER_ERR_EN
  logic set_err_q;

  // Sticky flag: a set that ends before the last lane, or fills it without in_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_err_q <= 1'b0;
    end else if (set_done && !(at_last_lane && in_last)) begin
      set_err_q <= 1'b1;
    end
  end

  assign set_err = set_err_q;
`endif

endmodule
